// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command FIFO and single-issue sequencer in front of the
// unsigned 8-bit ALU. Each command is popped, issued for one cycle, and its
// registered result is captured and returned with the command's tag.
// Illegal opcodes (110/111) are answered with an error and never issued.
// Optional feature macro: ALU_ISSUE_B2B_EN pops the next command on the
// response handshake and skips the IDLE cycle.
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [7:0]       cmd_a_i,
    input  logic [7:0]       cmd_b_i,
    input  logic [2:0]       cmd_op_i,
    input  logic [TAG_W-1:0] cmd_tag_i,
    output logic             alu_en_o,
    output logic [7:0]       alu_a_o,
    output logic [7:0]       alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [15:0]      alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    cmd_t             mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    state_t           state_q, state_d;
    logic             alu_en_q, rsp_valid_q, rsp_err_q;
    logic [7:0]       alu_a_q, alu_b_q;
    logic [2:0]       alu_op_q;
    logic [TAG_W-1:0] tag_q, rsp_tag_q;
    logic [15:0]      rsp_result_q;

    logic push, pop, full, empty, head_ill;
    cmd_t head;

    // FIFO status; full blocks pushes even when a pop happens this cycle
    always_comb begin
        full        = (count_q == (AW+1)'(DEPTH));
        empty       = (count_q == '0);
        cmd_ready_o = !full;
        push        = cmd_valid_i && !full;
        head        = mem_q[rd_ptr_q];
        head_ill    = head.op[2] & head.op[1];
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // FIFO storage: data needs no reset, occupancy is tracked by count_q
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_a_i, cmd_b_i, cmd_op_i, cmd_tag_i};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sequencer next state and pop decision
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = head_ill ? RESP : EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: state_d = RESP;
            RESP: begin
                if (rsp_ready_i) begin
`ifdef ALU_ISSUE_B2B_EN
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = head_ill ? RESP : EXEC;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, ALU drive and response registers; all outputs come from flops
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_en_q     <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_en_q    <= (state_d == EXEC);
            rsp_valid_q <= (state_d == RESP);
            if (pop) begin
                alu_a_q  <= head.a;
                alu_b_q  <= head.b;
                alu_op_q <= head.op;
                tag_q    <= head.tag;
                // Illegal ops answer straight away with a zero result
                if (head_ill) begin
                    rsp_err_q    <= 1'b1;
                    rsp_result_q <= '0;
                    rsp_tag_q    <= head.tag;
                end
            end
            if (state_q == CAPT) begin
                rsp_result_q <= alu_result_i;
                rsp_err_q    <= 1'b0;
                rsp_tag_q    <= tag_q;
            end
        end
    end

    assign alu_en_o     = alu_en_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_op_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command front end for the unsigned 8-bit ALU. It accepts tagged operations over a valid/ready interface and buffers them in a small FIFO. It issues one operation at a time to the ALU's en/A/B/OP inputs and captures the ALU's registered 16-bit result. It returns each result with its tag over a valid/ready response interface and rejects illegal opcodes without issuing them.

## Interface
- DEPTH, 4: command FIFO entries; power of two, 2..16.
- TAG_W, 4: width of the command/response tag.

- CLK  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_a, cmd_b  in  8 each  operands.
- cmd_op  in  3  000 ADD, 001 MUL, 010 AND, 011 OR, 100 XOR, 101 NOTA; 110/111 illegal.
- cmd_tag  in  TAG_W  returned unchanged with the response.
- alu_en  out  1  ALU enable; registered.
- alu_a, alu_b  out  8 each  ALU operands; registered.
- alu_op  out  3  ALU opcode; registered.
- alu_result  in  16  ALU registered result, valid the cycle after alu_en.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  16  captured result; 0 on error.
- rsp_tag  out  TAG_W  tag of the response.
- rsp_err  out  1  1 = illegal opcode; the command was not issued.

## Operation
- FIFO
  - Push on cmd_valid && cmd_ready.
  - Pop only in the states listed below.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle, so there is no push-while-full.
  - Pointers wrap modulo DEPTH.
- On pop, the head entry is loaded into the alu_a/alu_b/alu_op/tag registers. These hold stable until the next pop.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop. Legal op goes to EXEC. Illegal op goes to RESP with rsp_err=1 and rsp_result=0. If the FIFO is empty, stay in IDLE.
  - EXEC: alu_en=1 for exactly this cycle. Next state is CAPT.
  - CAPT: rsp_result<=alu_result, rsp_err<=0, rsp_tag<=tag register. Next state is RESP.
  - RESP: rsp_valid=1, and all rsp_* outputs are held until rsp_ready. On the handshake, go to IDLE (see Configuration).
- alu_en is 0 in every state except EXEC. At most one command is in flight.
- No arithmetic is performed here. rsp_result is alu_result bit-for-bit; width rules belong to the ALU (ADD 9-bit zero-extended, MUL 16-bit, logic ops and NOTA zero-extended).
- Reset mid-operation: FIFO contents, in-flight command and pending response are discarded. The ALU shares rst_n.

## Timing
- Reset values: cmd_ready=1 (after reset), alu_en=0, alu_a=alu_b=0, alu_op=0, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_err=0. FSM is in IDLE and the FIFO is empty.
- Legal command accepted in cycle t with an empty FIFO and IDLE:
  - t+1 pop.
  - t+2 EXEC (alu_en=1).
  - t+3 CAPT.
  - t+4 rsp_valid=1. Latency is 4 cycles.
- Illegal command accepted in cycle t: pop at t+1, rsp_valid=1 at t+2.
- A response handshake in cycle r returns to IDLE at r+1. Throughput is one op per 4 cycles with rsp_ready tied high.
- Pushes continue while busy until full. Commands complete in FIFO order.

## Configuration
- ALU_ISSUE_B2B_EN
  - Defined: on the RESP handshake, if the FIFO is non-empty the head is popped in the same cycle. Next state is EXEC (legal) or RESP with error (illegal), skipping IDLE. Throughput is one op per 3 cycles.
  - Undefined: RESP always returns to IDLE, as described above.

## Test plan
- Reset: assert rst_n=0 for 2 cycles -> all outputs at reset values and cmd_ready=1.
- Single ADD: A=0xFF, B=0xFF, tag=3 accepted at t -> alu_en only at t+2; rsp_valid at t+4 with rsp_result=0x01FE, rsp_tag=3, rsp_err=0.
- Ordering and backpressure:
  - Push MUL 0xFF*0xFF (tag 1), NOTA A=0x0F (tag 2), XOR 0xAA^0x55 (tag 3) with rsp_ready=0 for 10 cycles, then 1.
  - Required responses in order: 0xFE01/1, 0x00F0/2, 0x00FF/3.
  - rsp_* must stay stable while stalled.
- Illegal op: op=110, tag=5 -> alu_en never asserted; rsp_valid 2 cycles after accept with rsp_err=1, rsp_result=0, rsp_tag=5.
- Full FIFO: with rsp_ready=0, push DEPTH+2 commands -> cmd_ready=0 exactly when DEPTH entries are buffered plus one command in flight. No command is lost or duplicated after release.
- Reset mid-flight: assert rst_n=0 during EXEC with 3 entries queued -> after reset no rsp_valid appears and the FIFO is empty. With ALU_ISSUE_B2B_EN defined, a second queued op reaches EXEC one cycle after the RESP handshake.
